dcache_direct: RTL and testbench
================================

Name: dcache_direct

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the MIPS core data port and a multi-cycle word-wide main memory.
- Core side mirrors the core data port: 32-bit address, four 8-bit byte lanes, lane 0 = most significant byte.
- Hits complete combinationally in the access cycle. Misses and all writes hold the core via cpu_stall while memory is serviced with a req/ack handshake.

Parameters:
INDEX_BITS, 5, log2 of line count (32 lines)
LINE_WORDS, 4, 32-bit words per line; power of two, >= 2

Ports:
clk  input  1  clock; all state updates on rising edge
rst_b  input  1  synchronous reset, active-HIGH despite the name: rst_b=1 at a clk edge resets the block
cpu_addr  input  32  byte address; bits [1:0] ignored (word access)
cpu_re  input  1  load request
cpu_we  input  1  store request
cpu_wdata  input  4x8  store data, lane 0 = bits [31:24]
cpu_rdata  output  4x8  load data, lane 0 = bits [31:24]
cpu_stall  output  1  core must hold its current instruction
mem_req  output  1  memory request valid
mem_we  output  1  1 = write, 0 = read; valid with mem_req
mem_addr  output  32  word-aligned memory address
mem_wdata  output  32  write data
mem_rdata  input  32  read data, valid with mem_ack
mem_ack  input  1  one-cycle completion pulse for the current request
hit_count  output  32  see Optional Feature
miss_count  output  32  see Optional Feature

Behaviour:
- Address split: WO = log2(LINE_WORDS). Word offset = [WO+1:2]; index = [INDEX_BITS+WO+1:WO+2]; tag = the remaining upper bits.
- Storage: per line, one valid bit, a tag, and LINE_WORDS data words. Valid bits are flops.
- Reset: all valid bits cleared in one cycle, state = IDLE, fill counter = 0. Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_stall=0, cpu_rdata=0.
- Reset mid-operation: aborts FILL or WRITE; mem_req=0 from the next cycle. A partially filled line is left invalid. A late mem_ack is ignored.
- States: IDLE, FILL, WRITE, WDONE.
- IDLE, cpu_we=1 (has priority over cpu_re):
  - cpu_stall=1 combinationally.
  - On a tag hit, the data word is updated at this edge. On a miss, nothing is allocated.
  - Address and data are latched; go to WRITE.
- IDLE, cpu_re=1 and hit: cpu_rdata = stored word in the same cycle, cpu_stall=0, no memory traffic.
- IDLE, cpu_re=1 and miss:
  - cpu_stall=1; the target line is invalidated.
  - Tag and index are latched, counter = 0; go to FILL.
- IDLE, neither request: cpu_rdata=0, cpu_stall=0.
- FILL:
  - mem_req=1, mem_we=0, mem_addr = {latched tag, index, counter, 2'b00}.
  - On mem_ack: mem_rdata is written to word[counter] and the counter increments.
  - On ack of the last word: set valid, write the tag, go to IDLE.
  - The core re-presents the load and it hits. Miss latency = LINE_WORDS acks + 1 cycle.
- WRITE:
  - mem_req=1, mem_we=1, with the latched address and data; cpu_stall=1.
  - On mem_ack, go to WDONE.
- WDONE:
  - cpu_stall=0 for exactly one cycle so the core retires the store.
  - cpu_we/cpu_re are ignored this cycle; go to IDLE.
- Handshake rules:
  - mem_req and its address/data stay stable until mem_ack.
  - mem_req drops the cycle after the final ack.
  - mem_ack while mem_req=0 is ignored.
- cpu_rdata = 0 whenever cpu_stall=1.

Optional Feature:
DCACHE_STATS_EN defined:
- hit_count increments once per IDLE cycle with cpu_re=1 and cpu_we=0 that hits.
- miss_count increments once per entry into FILL.
- Both counters reset to 0 and wrap modulo 2^32.

DCACHE_STATS_EN undefined:
- Both ports are tied to 0 and no counter logic is generated.

Test Plan:
- Defaults (INDEX_BITS=5, LINE_WORDS=4): index = addr[8:4], tag = addr[31:9].
- Cold read miss: reset, then read 0x100 → stall=1; mem_req reads 0x100, 0x104, 0x108, 0x10C, acked with 0x11111111..0x44444444 → after the final ack plus one cycle, stall=0 and cpu_rdata=0x11111111; miss_count=1 with DCACHE_STATS_EN.
- Read hit: read 0x108 after the fill → stall=0 in the same cycle, cpu_rdata=0x33333333, mem_req stays 0; hit_count increments.
- Store hit: write 0x104 with lanes {DE,AD,BE,EF} → mem_req=1, mem_we=1, addr=0x104, wdata=0xDEADBEEF until ack; one WDONE cycle with stall=0. Then read 0x104 hits, returning 0xDEADBEEF.
- Conflict eviction: read 0x300 (same index 0x10, different tag) → fill from 0x300..0x30C; a following read of 0x100 misses and refills.
- Reset mid-fill: read 0x100, ack 2 words, assert rst_b=1 for one cycle → mem_req=0 the next cycle. Re-reading 0x100 misses and fetches from 0x100.
- Store miss, no allocate: write 0x400 → memory write issued; a later read of 0x400 misses (FILL from 0x400).

Source files
------------

// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache for the core data port.
// Define DCACHE_STATS_EN to build the hit/miss counters; otherwise both count ports read 0.
module dcache_direct #(
   parameter int unsigned INDEX_BITS = 5,
   parameter int unsigned LINE_WORDS = 4
) (
   input  logic            clk,
   input  logic            rst_b,
   input  logic [31:0]     cpu_addr,
   input  logic            cpu_re,
   input  logic            cpu_we,
   input  logic [0:3][7:0] cpu_wdata,
   output logic [0:3][7:0] cpu_rdata,
   output logic            cpu_stall,
   output logic            mem_req,
   output logic            mem_we,
   output logic [31:0]     mem_addr,
   output logic [31:0]     mem_wdata,
   input  logic [31:0]     mem_rdata,
   input  logic            mem_ack,
   output logic [31:0]     hit_count,
   output logic [31:0]     miss_count
);
   localparam int unsigned WO      = $clog2(LINE_WORDS);
   localparam int unsigned TagBits = 32 - INDEX_BITS - WO - 2;
   localparam int unsigned Lines   = 1 << INDEX_BITS;

   typedef enum logic [1:0] {StIdle, StFill, StWrite, StWdone} state_e;

   state_e state_q, state_d;

   logic [WO-1:0]         addr_off;
   logic [INDEX_BITS-1:0] addr_idx;
   logic [TagBits-1:0]    addr_tag;
   logic [1:0]            unused_addr;

   assign addr_off    = cpu_addr[WO+1:2];
   assign addr_idx    = cpu_addr[INDEX_BITS+WO+1:WO+2];
   assign addr_tag    = cpu_addr[31:INDEX_BITS+WO+2];
   assign unused_addr = cpu_addr[1:0];

   logic [Lines-1:0]   valid_q;
   logic [TagBits-1:0] tag_q  [Lines];
   logic [31:0]        data_q [Lines*LINE_WORDS];

   // Miss / store bookkeeping latched on leaving IDLE
   logic [WO-1:0]         cnt_q;
   logic [TagBits-1:0]    ltag_q;
   logic [INDEX_BITS-1:0] lidx_q;
   logic [31:0]           waddr_q;
   logic [31:0]           wdata_q;

   logic        hit;
   logic [31:0] rd_word;
   logic        fill_start;
   logic        wr_start;
   logic        store_hit;
   logic        fill_ack;
   logic        last_word;

   assign hit        = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
   assign rd_word    = data_q[{addr_idx, addr_off}];
   assign wr_start   = (state_q == StIdle) && cpu_we;
   assign fill_start = (state_q == StIdle) && !cpu_we && cpu_re && !hit;
   assign store_hit  = wr_start && hit;
   assign fill_ack   = (state_q == StFill) && mem_ack;
   assign last_word  = &cnt_q;

   always_ff @(posedge clk) begin
      if (rst_b) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (cpu_we) begin
               state_d = StWrite;
            end else if (cpu_re && !hit) begin
               state_d = StFill;
            end
         end
         StFill:  if (mem_ack && last_word) state_d = StIdle;
         StWrite: if (mem_ack) state_d = StWdone;
         StWdone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cpu_stall = 1'b0;
      cpu_rdata = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      unique case (state_q)
         StIdle: begin
            if (cpu_we) begin
               cpu_stall = 1'b1;
            end else if (cpu_re) begin
               if (hit) begin
                  cpu_rdata = rd_word;
               end else begin
                  cpu_stall = 1'b1;
               end
            end
         end
         StFill: begin
            cpu_stall = 1'b1;
            mem_req   = 1'b1;
            mem_addr  = {ltag_q, lidx_q, cnt_q, 2'b00};
         end
         StWrite: begin
            cpu_stall = 1'b1;
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = waddr_q;
            mem_wdata = wdata_q;
         end
         default: ;
      endcase
   end

   // Line is invalid for the whole fill, so a reset mid-fill leaves it invalid
   always_ff @(posedge clk) begin
      if (rst_b) begin
         valid_q <= '0;
         cnt_q   <= '0;
      end else begin
         if (fill_start) begin
            valid_q[addr_idx] <= 1'b0;
            cnt_q             <= '0;
         end
         if (fill_ack) begin
            cnt_q <= cnt_q + WO'(1);
            if (last_word) valid_q[lidx_q] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fill_start) begin
         ltag_q <= addr_tag;
         lidx_q <= addr_idx;
      end
      if (wr_start) begin
         waddr_q <= {cpu_addr[31:2], 2'b00};
         wdata_q <= cpu_wdata;
      end
      if (store_hit) data_q[{addr_idx, addr_off}] <= cpu_wdata;
      if (fill_ack) begin
         data_q[{lidx_q, cnt_q}] <= mem_rdata;
         if (last_word) tag_q[lidx_q] <= ltag_q;
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_q, miss_q;

   always_ff @(posedge clk) begin
      if (rst_b) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else begin
         if ((state_q == StIdle) && cpu_re && !cpu_we && hit) hit_q <= hit_q + 32'd1;
         if (fill_start) miss_q <= miss_q + 32'd1;
      end
   end

   assign hit_count  = hit_q;
   assign miss_count = miss_q;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_direct.sv
// Bench for dcache_direct: directed vector table, hand-written corner sequences and random
// traffic against a line-level cache/memory model with a randomly-acking memory.
module tb_dcache_direct;
   localparam int unsigned LW = 4;

`ifdef DCACHE_STATS_EN
   localparam bit StatsOn = 1'b1;
`else
   localparam bit StatsOn = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_b;
   logic [31:0]     cpu_addr;
   logic            cpu_re;
   logic            cpu_we;
   logic [0:3][7:0] cpu_wdata;
   logic [0:3][7:0] cpu_rdata;
   logic            cpu_stall;
   logic            mem_req;
   logic            mem_we;
   logic [31:0]     mem_addr;
   logic [31:0]     mem_wdata;
   logic [31:0]     mem_rdata;
   logic            mem_ack;
   logic [31:0]     hit_count;
   logic [31:0]     miss_count;

   always #5 clk = ~clk;

   dcache_direct #(
      .INDEX_BITS (5),
      .LINE_WORDS (LW)
   ) dut (
      .clk        (clk),
      .rst_b      (rst_b),
      .cpu_addr   (cpu_addr),
      .cpu_re     (cpu_re),
      .cpu_we     (cpu_we),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   typedef enum int {AckNever, AckAlways, AckRandom, AckSpur} ack_mode_e;

   // Model: which tag each line holds, and what memory should contain
   bit          m_valid [32];
   logic [22:0] m_tag   [32];
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] ext_mem [logic [31:0]];
   int unsigned m_hits;
   int unsigned m_misses;

   ack_mode_e   ack_mode = AckNever;
   logic [31:0] fill_log [$];
   logic [63:0] wr_log   [$];

   int n_cmp  = 0;
   int n_fail = 0;

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return dflt(a);
   endfunction

   function automatic logic [31:0] ext_rd(input logic [31:0] a);
      if (ext_mem.exists(a)) return ext_mem[a];
      return dflt(a);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory responder: decides ack at the falling edge, serves/absorbs data at the same time
   initial begin : responder
      bit go;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         unique case (ack_mode)
            AckAlways: go = (mem_req === 1'b1);
            AckRandom: go = (mem_req === 1'b1) && ($urandom_range(0, 1) == 1);
            AckSpur:   go = 1'b1;
            default:   go = 1'b0;
         endcase
         mem_ack   = go;
         mem_rdata = go ? ext_rd(mem_addr) : 32'h0;
         if (go && mem_req === 1'b1) begin
            if (mem_we) begin
               ext_mem[mem_addr] = mem_wdata;
               wr_log.push_back({mem_addr, mem_wdata});
            end else begin
               fill_log.push_back(mem_addr);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
      m_hits   = 0;
      m_misses = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_b  = 1'b1;
      cpu_re = 1'b0;
      cpu_we = 1'b0;
      @(posedge clk); #1;
      rst_b = 1'b0;
      model_reset();
   endtask

   task automatic do_idle();
      @(posedge clk); #1;
      cpu_re = 1'b0;
      cpu_we = 1'b0;
      #2;
   endtask

   // One core access held until the cache releases the stall; model-based checks inside
   task automatic do_access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                            output logic first_stall, output logic [31:0] last_rdata,
                            output int lat);
      logic [31:0] wa;
      logic [31:0] base;
      int          idx;
      logic [22:0] tg;
      bit          hit;
      bit          rd_leak;
      bit          done;
      wa   = {addr[31:2], 2'b00};
      base = addr & ~32'(LW * 4 - 1);
      idx  = int'(addr[8:4]);
      tg   = addr[31:9];
      hit  = m_valid[idx] && (m_tag[idx] == tg);
      @(posedge clk); #1;
      cpu_addr  = addr;
      cpu_we    = wr;
      cpu_re    = !wr;
      cpu_wdata = wd;
      fill_log.delete();
      wr_log.delete();
      #2;
      check("hit_count", hit_count, StatsOn ? 32'(m_hits) : 32'h0);
      check("miss_count", miss_count, StatsOn ? 32'(m_misses) : 32'h0);
      first_stall = cpu_stall;
      lat = 0;
      if (!wr && hit) begin
         check("hit_stall", 32'(cpu_stall), 32'h0);
         check("hit_rdata", cpu_rdata, ref_rd(wa));
         check("hit_mem_req", 32'(mem_req), 32'h0);
         last_rdata = cpu_rdata;
         m_hits++;
      end else begin
         check("first_stall", 32'(cpu_stall), 32'h1);
         check("stall_rdata", cpu_rdata, 32'h0);
         lat     = 1;
         rd_leak = 1'b0;
         done    = 1'b0;
         while (!done && lat <= 400) begin
            @(posedge clk); #3;
            if (!cpu_stall) begin
               done = 1'b1;
            end else begin
               if (cpu_rdata != 0) rd_leak = 1'b1;
               lat++;
            end
         end
         check("stall_release", 32'(done), 32'h1);
         check("rdata_while_stalled", 32'(rd_leak), 32'h0);
         last_rdata = cpu_rdata;
         if (!wr) begin
            check("fill_words", 32'(fill_log.size()), 32'(LW));
            for (int i = 0; i < int'(LW) && i < fill_log.size(); i++)
               check("fill_addr", fill_log[i], base + 32'(4 * i));
            check("miss_rdata", cpu_rdata, ref_rd(wa));
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_misses++;
            m_hits++;
         end else begin
            check("mem_writes", 32'(wr_log.size()), 32'h1);
            if (wr_log.size() > 0) begin
               check("wr_addr", wr_log[0][63:32], wa);
               check("wr_data", wr_log[0][31:0], wd);
            end
            ref_mem[wa] = wd;
         end
      end
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wd;
      bit          exp_stall;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } vec_t;

   vec_t        vecs [11];
   logic        fs;
   logic [31:0] rd;
   int          lat;

   initial begin
      rst_b     = 1'b1;
      cpu_addr  = '0;
      cpu_re    = 1'b0;
      cpu_we    = 1'b0;
      cpu_wdata = '0;
      for (int i = 0; i < 4; i++) begin
         ref_mem[32'h100 + 32'(4 * i)] = 32'h1111_1111 * 32'(i + 1);
         ref_mem[32'h300 + 32'(4 * i)] = 32'h1111_1111 * 32'(i + 5);
      end
      ext_mem = ref_mem;

      // miss latency with an ack every cycle: 1 request cycle + LW fill cycles
      vecs[0]  = '{1'b0, 32'h100, 32'h0,          1'b1, 32'h1111_1111, 5};
      vecs[1]  = '{1'b0, 32'h108, 32'h0,          1'b0, 32'h3333_3333, 0};
      vecs[2]  = '{1'b1, 32'h104, 32'hDEAD_BEEF,  1'b1, 32'h0,         2};
      vecs[3]  = '{1'b0, 32'h104, 32'h0,          1'b0, 32'hDEAD_BEEF, 0};
      vecs[4]  = '{1'b0, 32'h300, 32'h0,          1'b1, 32'h5555_5555, 5};
      vecs[5]  = '{1'b0, 32'h30C, 32'h0,          1'b0, 32'h8888_8888, 0};
      vecs[6]  = '{1'b0, 32'h100, 32'h0,          1'b1, 32'h1111_1111, 5};
      vecs[7]  = '{1'b1, 32'h400, 32'h1234_5678,  1'b1, 32'h0,         2};
      vecs[8]  = '{1'b0, 32'h400, 32'h0,          1'b1, 32'h1234_5678, 5};
      vecs[9]  = '{1'b0, 32'h10C, 32'h0,          1'b0, 32'h4444_4444, 0};
      vecs[10] = '{1'b0, 32'h102, 32'h0,          1'b0, 32'h1111_1111, 0};

      do_reset();
      #2;
      check("rst_stall", 32'(cpu_stall), 32'h0);
      check("rst_mem_req", 32'(mem_req), 32'h0);
      check("rst_mem_we", 32'(mem_we), 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_rdata", cpu_rdata, 32'h0);
      check("rst_hit_count", hit_count, 32'h0);
      check("rst_miss_count", miss_count, 32'h0);

      ack_mode = AckAlways;
      for (int i = 0; i < 11; i++) begin
         do_access(vecs[i].wr, vecs[i].addr, vecs[i].wd, fs, rd, lat);
         check("vec_stall", 32'(fs), 32'(vecs[i].exp_stall));
         check("vec_latency", 32'(lat), 32'(vecs[i].exp_lat));
         if (!vecs[i].wr) check("vec_rdata", rd, vecs[i].exp_rdata);
      end

      // Store with a slow memory: request must hold steady, then one WDONE cycle
      ack_mode = AckNever;
      @(posedge clk); #1;
      cpu_addr  = 32'h108;
      cpu_we    = 1'b1;
      cpu_re    = 1'b0;
      cpu_wdata = 32'hCAFE_F00D;
      #2;
      check("st_first_stall", 32'(cpu_stall), 32'h1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #3;
         check("st_req", 32'(mem_req), 32'h1);
         check("st_we", 32'(mem_we), 32'h1);
         check("st_addr", mem_addr, 32'h108);
         check("st_wdata", mem_wdata, 32'hCAFE_F00D);
         check("st_stall", 32'(cpu_stall), 32'h1);
      end
      ack_mode = AckAlways;
      @(posedge clk); #3;
      check("wdone_stall", 32'(cpu_stall), 32'h0);
      check("wdone_req", 32'(mem_req), 32'h0);
      ref_mem[32'h108] = 32'hCAFE_F00D;
      do_idle();
      check("post_wdone_req", 32'(mem_req), 32'h0);
      check("post_wdone_stall", 32'(cpu_stall), 32'h0);
      do_access(1'b0, 32'h108, 32'h0, fs, rd, lat);
      check("store_hit_readback", rd, 32'hCAFE_F00D);

      // Reset in the middle of a fill, then spurious acks while idle
      do_reset();
      ack_mode = AckAlways;
      @(posedge clk); #1;
      cpu_addr = 32'h100;
      cpu_re   = 1'b1;
      cpu_we   = 1'b0;
      #2;
      check("mf_stall", 32'(cpu_stall), 32'h1);
      @(posedge clk); #3;
      check("mf_req", 32'(mem_req), 32'h1);
      check("mf_addr0", mem_addr, 32'h100);
      @(posedge clk); #3;
      check("mf_addr1", mem_addr, 32'h104);
      @(posedge clk); #1;
      rst_b    = 1'b1;
      ack_mode = AckNever;
      #2;
      check("mf_addr2", mem_addr, 32'h108);
      @(posedge clk); #1;
      rst_b  = 1'b0;
      cpu_re = 1'b0;
      model_reset();
      #2;
      check("mf_abort_req", 32'(mem_req), 32'h0);
      check("mf_abort_stall", 32'(cpu_stall), 32'h0);
      ack_mode = AckSpur;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #3;
         check("spur_req", 32'(mem_req), 32'h0);
         check("spur_stall", 32'(cpu_stall), 32'h0);
      end
      ack_mode = AckAlways;
      do_access(1'b0, 32'h100, 32'h0, fs, rd, lat);
      check("mf_reread_miss", 32'(fs), 32'h1);
      check("mf_reread_data", rd, 32'h1111_1111);

      // Random traffic over a few conflicting tags and indices
      ack_mode = AckRandom;
      for (int n = 0; n < 200; n++) begin
         logic [31:0] a;
         bit          w;
         a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 4)
             | 32'($urandom_range(0, 15));
         w = ($urandom_range(0, 9) < 4);
         do_access(w, a, $urandom, fs, rd, lat);
      end

      do_idle();
      check("final_hit_count", hit_count, StatsOn ? 32'(m_hits) : 32'h0);
      check("final_miss_count", miss_count, StatsOn ? 32'(m_misses) : 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
